// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ranger: issues a trigger, times the echo pulse against a 1 us tick
// strobe and reports whole centimetres, with saturation, echo timeout and holdoff.
module ultrasonic_ranger #(
    parameter int TRIG_TICKS      = 10,
    parameter int US_PER_CM       = 58,
    parameter int MAX_CM          = 400,
    parameter int ECHO_WAIT_TICKS = 30000,
    parameter int HOLDOFF_TICKS   = 60000,
    parameter int AUTO_START      = 1,
    parameter int DIST_W          = 9
) (
    input  logic              ClockIn,
    input  logic              Reset,
    input  logic              TickIn,
    input  logic              StartIn,
    input  logic              EchoIn,
    output logic              TriggerOut,
    output logic [DIST_W-1:0] DistanceOut,
    output logic              DistanceValid,
    output logic              OverRange,
    output logic              TimeoutOut,
    output logic              Busy
);

    localparam int CNT_MAX = (ECHO_WAIT_TICKS > HOLDOFF_TICKS) ? ECHO_WAIT_TICKS : HOLDOFF_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int SUB_W   = (US_PER_CM > 2) ? $clog2(US_PER_CM) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DRAIN,
        HOLDOFF
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        tick_sync_q, echo_sync_q;
    logic              tick_prev_q, echo_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              over_q, over_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              trig_q;
    logic              tick, echo_s, echo_rise, sat;

    // True on the tick that completes a window of 'limit' ticks.
    function automatic logic last_tick(input logic [CNT_W-1:0] cnt, input int limit);
        return cnt == CNT_W'(limit - 1);
    endfunction

    assign tick      = tick_sync_q[1] & ~tick_prev_q;
    assign echo_s    = echo_sync_q[1];
    assign echo_rise = echo_sync_q[1] & ~echo_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        dist_d    = dist_q;
        over_d    = over_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        sat       = 1'b0;
        case (state_q)
            IDLE: begin
                if (AUTO_START != 0 || StartIn) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
            end
            TRIG: begin
                // Leaving on tick TRIG_TICKS+1 guarantees TRIG_TICKS whole ticks high.
                if (tick) begin
                    if (last_tick(cnt_q, TRIG_TICKS + 1)) begin
                        state_d = WAIT_ECHO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (last_tick(cnt_q, ECHO_WAIT_TICKS)) begin
                        timeout_d = 1'b1;
                        state_d   = HOLDOFF;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MEASURE: begin
                // A tick coinciding with the echo fall is counted before the result is taken.
                if (tick) begin
                    if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                        sub_d = '0;
                        if (cm_q == DIST_W'(MAX_CM)) sat = 1'b1;
                        else cm_d = cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                if (sat) begin
                    dist_d  = DIST_W'(MAX_CM);
                    over_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (!echo_s) begin
                    dist_d  = cm_d;
                    over_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (!echo_s) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (last_tick(cnt_q, ECHO_WAIT_TICKS)) begin
                        timeout_d = 1'b1;
                        state_d   = HOLDOFF;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (tick) begin
                    if (last_tick(cnt_q, HOLDOFF_TICKS)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            tick_sync_q <= '0;
            echo_sync_q <= '0;
            tick_prev_q <= 1'b0;
            echo_prev_q <= 1'b0;
            cnt_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            dist_q      <= '0;
            over_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_sync_q <= {tick_sync_q[0], TickIn};
            echo_sync_q <= {echo_sync_q[0], EchoIn};
            tick_prev_q <= tick_sync_q[1];
            echo_prev_q <= echo_sync_q[1];
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            dist_q      <= dist_d;
            over_q      <= over_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            trig_q      <= (state_d == TRIG);
        end
    end

    assign TriggerOut    = trig_q;
    assign DistanceOut   = dist_q;
    assign DistanceValid = valid_q;
    assign OverRange     = over_q;
    assign TimeoutOut    = timeout_q;
    assign Busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened timing windows and an 8-clock tick.
module tb_ultrasonic_ranger;

    localparam int TRIG_TICKS      = 10;
    localparam int US_PER_CM       = 58;
    localparam int MAX_CM          = 20;
    localparam int ECHO_WAIT_TICKS = 300;
    localparam int HOLDOFF_TICKS   = 200;
    localparam int DIST_W          = 9;
    localparam int TICK_CLKS       = 8;
    localparam int TICK_TIME       = 80;
    localparam int BUDGET          = 20000;

    logic              ClockIn, Reset, TickIn, StartIn, EchoIn;
    logic              TriggerOut, DistanceValid, OverRange, TimeoutOut, Busy;
    logic [DIST_W-1:0] DistanceOut;

    int     n_checks = 0;
    int     n_errors = 0;
    int     r_valid, r_tmo, r_valid_tick, r_tmo_tick, r_trig_clks, r_after_low;
    int     r_dist, r_over;
    bit     r_done;
    longint r_valid_time, t_prev;
    int     busy_cnt, trig_cnt;

    ultrasonic_ranger #(
        .TRIG_TICKS(TRIG_TICKS),
        .US_PER_CM(US_PER_CM),
        .MAX_CM(MAX_CM),
        .ECHO_WAIT_TICKS(ECHO_WAIT_TICKS),
        .HOLDOFF_TICKS(HOLDOFF_TICKS),
        .AUTO_START(0),
        .DIST_W(DIST_W)
    ) dut (
        .ClockIn(ClockIn),
        .Reset(Reset),
        .TickIn(TickIn),
        .StartIn(StartIn),
        .EchoIn(EchoIn),
        .TriggerOut(TriggerOut),
        .DistanceOut(DistanceOut),
        .DistanceValid(DistanceValid),
        .OverRange(OverRange),
        .TimeoutOut(TimeoutOut),
        .Busy(Busy)
    );

    initial begin
        ClockIn = 0;
        forever #5 ClockIn = ~ClockIn;
    end

    // Tick edges are offset from every clock edge so sampling is unambiguous.
    initial begin
        TickIn = 0;
        #2;
        forever #40 TickIn = ~TickIn;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One measurement cycle: waits for the trigger, drives the echo in tick units
    // relative to the trigger fall, and records what the DUT reports until it idles.
    task automatic run_meas(input int rise_after, input int width, input bit pre_high,
                            input int reset_at, input bit oneshot, input int pulse_at);
        bit trig_seen = 0, trig_fell = 0, raised = 0, lowered = 0, pulse_on = 0, done = 0;
        bit tick_prev, tick_e;
        int since_fall = 0, echo_ticks = 0, after_low = 0;
        r_valid = 0; r_tmo = 0; r_valid_tick = -1; r_tmo_tick = -1; r_trig_clks = 0;
        r_dist = -1; r_over = -1;
        if (pre_high) EchoIn = 1;
        tick_prev = TickIn;
        for (int c = 0; c < BUDGET && !done; c++) begin
            @(negedge ClockIn);
            tick_e = TickIn && !tick_prev;
            tick_prev = TickIn;
            if (pulse_on) begin
                StartIn = 0;
                pulse_on = 0;
            end
            if (!trig_fell) begin
                if (TriggerOut) begin
                    trig_seen = 1;
                    r_trig_clks++;
                    if (oneshot) StartIn = 0;
                end else if (trig_seen) begin
                    trig_fell = 1;
                end
            end else begin
                if (tick_e) since_fall++;
                if (tick_e && raised && !lowered) echo_ticks++;
                if (tick_e && lowered) after_low++;
                if (!raised && !pre_high && rise_after > 0 && tick_e && since_fall == rise_after) begin
                    EchoIn = 1;
                    raised = 1;
                end else if (raised && !lowered && tick_e && echo_ticks == width) begin
                    EchoIn = 0;
                    lowered = 1;
                end
                if (pulse_at > 0 && raised && !lowered && tick_e && echo_ticks == pulse_at) begin
                    StartIn = 1;
                    pulse_on = 1;
                end
                if (DistanceValid) begin
                    r_valid++;
                    r_dist = int'(DistanceOut);
                    r_over = int'(OverRange);
                    r_valid_tick = echo_ticks;
                    r_valid_time = $time;
                end
                if (TimeoutOut) begin
                    r_tmo++;
                    r_tmo_tick = since_fall;
                    if (pre_high) begin
                        EchoIn = 0;
                        lowered = 1;
                    end
                end
                if (reset_at > 0 && raised && !lowered && echo_ticks == reset_at) begin
                    Reset = 1;
                    #1;
                    check_eq("rst_ctrl_outs", {TriggerOut, DistanceValid, OverRange, TimeoutOut, Busy}, 0);
                    check_eq("rst_distance", DistanceOut, 0);
                    EchoIn = 0;
                    done = 1;
                end
                if (!Busy) done = 1;
            end
        end
        r_after_low = after_low;
        r_done = done;
        check_eq("cycle_budget", done, 1);
    endtask

    initial begin
        Reset = 1;
        StartIn = 0;
        EchoIn = 0;
        repeat (5) @(negedge ClockIn);
        check_eq("reset_ctrl_outs", {TriggerOut, DistanceValid, OverRange, TimeoutOut, Busy}, 0);
        check_eq("reset_distance", DistanceOut, 0);
        Reset = 0;

        // StartIn low: the ranger must stay idle.
        busy_cnt = 0; trig_cnt = 0;
        repeat (500) begin
            @(negedge ClockIn);
            if (Busy) busy_cnt++;
            if (TriggerOut) trig_cnt++;
        end
        check_eq("idle_busy_cycles", busy_cnt, 0);
        check_eq("idle_trig_cycles", trig_cnt, 0);

        StartIn = 1;
        run_meas(5, 580, 0, 0, 0, 0);
        check_eq("trig_len_ok", r_trig_clks >= TRIG_TICKS * TICK_CLKS, 1);
        check_eq("d580_dist", r_dist, 10);
        check_eq("d580_over", r_over, 0);
        check_eq("d580_valid_pulses", r_valid, 1);
        check_eq("d580_timeouts", r_tmo, 0);

        run_meas(5, 57, 0, 0, 0, 0);
        check_eq("d57_dist", r_dist, 0);
        check_eq("d57_valid_pulses", r_valid, 1);
        t_prev = r_valid_time;

        run_meas(5, 58, 0, 0, 0, 0);
        check_eq("d58_dist", r_dist, 1);
        check_eq("d58_valid_pulses", r_valid, 1);
        check_eq("valid_gap_ok", (r_valid_time - t_prev) / TICK_TIME >= HOLDOFF_TICKS, 1);

        // Saturates on tick (MAX_CM+1)*US_PER_CM = 1218 while echo is still high.
        run_meas(5, 1400, 0, 0, 0, 0);
        check_eq("sat_dist", r_dist, MAX_CM);
        check_eq("sat_over", r_over, 1);
        check_eq("sat_valid_pulses", r_valid, 1);
        check_eq("sat_valid_tick", r_valid_tick, 1218);
        check_eq("sat_timeouts", r_tmo, 0);
        check_eq("sat_holdoff_ok", r_after_low >= HOLDOFF_TICKS, 1);

        run_meas(0, 0, 0, 0, 0, 0);
        check_eq("norise_timeouts", r_tmo, 1);
        check_eq("norise_tmo_tick", r_tmo_tick, ECHO_WAIT_TICKS);
        check_eq("norise_valid_pulses", r_valid, 0);
        check_eq("norise_dist_kept", DistanceOut, MAX_CM);
        check_eq("norise_over_kept", OverRange, 1);

        run_meas(0, 0, 1, 0, 0, 0);
        check_eq("stuck_timeouts", r_tmo, 1);
        check_eq("stuck_tmo_tick", r_tmo_tick, ECHO_WAIT_TICKS);
        check_eq("stuck_valid_pulses", r_valid, 0);
        check_eq("stuck_dist_kept", DistanceOut, MAX_CM);

        run_meas(5, 1160, 0, 300, 0, 0);
        repeat (3) @(negedge ClockIn);
        Reset = 0;

        // Single start; a StartIn pulse mid-measurement must not queue another cycle.
        StartIn = 1;
        run_meas(5, 1160, 0, 0, 1, 100);
        check_eq("post_rst_dist", r_dist, 20);
        check_eq("post_rst_over", r_over, 0);
        check_eq("post_rst_valid_pulses", r_valid, 1);
        busy_cnt = 0; trig_cnt = 0;
        repeat (1500) begin
            @(negedge ClockIn);
            if (Busy) busy_cnt++;
            if (TriggerOut) trig_cnt++;
        end
        check_eq("no_requeue_busy", busy_cnt, 0);
        check_eq("no_requeue_trig", trig_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
